// File: rtl/tvec_sequencer.sv
// tvec_sequencer
//   Steps a combinational circuit under test through a stored test-vector
//   table. For each vector it reads the word from a synchronous memory, drives
//   the stimulus, waits SETTLE cycles, samples the circuit response and
//   compares it with the golden value. Mismatches are counted with saturation.
//
// Parameters
//   IN_W    stimulus width
//   OUT_W   circuit output width
//   ADDR_W  vector memory address width
//   SETTLE  cycles between driving stimulus and sampling output (1..255)
//   CNT_W   error counter width
//
// Ports
//   clk       clock
//   rst_n     asynchronous active-low reset
//   start     begin a run (sampled only when idle)
//   abort     terminate a run (highest priority)
//   num_vec   number of vectors, latched on start
//   vec_rd    memory read strobe
//   vec_addr  memory address
//   vec_data  memory word, valid one cycle after vec_rd: {stimulus, expected}
//   dut_in    stimulus to the circuit under test
//   dut_out   circuit response
//   busy      run in progress
//   done      one-cycle pulse when a run completes
//   err_cnt   mismatch count of the current or last run
//
// Optional build macro TVEC_FIRST_FAIL_CAPTURE_EN adds:
//   fail_valid  a mismatch has been captured in this run
//   fail_addr   address of the first mismatching vector
//   fail_got    circuit response at the first mismatch
module tvec_sequencer #(
  parameter int unsigned IN_W   = 3,
  parameter int unsigned OUT_W  = 1,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_W-1:0]       num_vec,
  output logic                    vec_rd,
  output logic [ADDR_W-1:0]       vec_addr,
  input  logic [IN_W+OUT_W-1:0]   vec_data,
  output logic [IN_W-1:0]         dut_in,
  input  logic [OUT_W-1:0]        dut_out,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        err_cnt
`ifdef TVEC_FIRST_FAIL_CAPTURE_EN
  ,
  output logic                    fail_valid,
  output logic [ADDR_W-1:0]       fail_addr,
  output logic [OUT_W-1:0]        fail_got
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WAIT,
    S_SAMPLE
  } state_t;

  localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t            state;
  logic [ADDR_W-1:0] num_q;
  logic [OUT_W-1:0]  exp_q;
  logic [7:0]        settle_cnt;
  logic              mismatch;
  logic              last_vec;

  always_comb begin
    mismatch = (dut_out != exp_q);
    last_vec = (vec_addr == (num_q - ADDR_W'(1)));
  end

  // vec_rd is registered so it is high exactly during FETCH; it is set on the
  // transition into FETCH and cleared by default every other cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      vec_rd     <= 1'b0;
      vec_addr   <= '0;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_cnt    <= '0;
      num_q      <= '0;
      exp_q      <= '0;
      settle_cnt <= '0;
`ifdef TVEC_FIRST_FAIL_CAPTURE_EN
      fail_valid <= 1'b0;
      fail_addr  <= '0;
      fail_got   <= '0;
`endif
    end else begin
      done   <= 1'b0;
      vec_rd <= 1'b0;
      if (state != S_IDLE && abort) begin
        // err_cnt, dut_in and vec_addr deliberately hold
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              err_cnt <= '0;
`ifdef TVEC_FIRST_FAIL_CAPTURE_EN
              fail_valid <= 1'b0;
              fail_addr  <= '0;
              fail_got   <= '0;
`endif
              if (num_vec != '0) begin
                num_q    <= num_vec;
                vec_addr <= '0;
                vec_rd   <= 1'b1;
                busy     <= 1'b1;
                state    <= S_FETCH;
              end else begin
                // empty run: report completion without ever going busy
                done <= 1'b1;
              end
            end
          end

          S_FETCH: begin
            state <= S_LOAD;
          end

          S_LOAD: begin
            dut_in     <= vec_data[IN_W+OUT_W-1:OUT_W];
            exp_q      <= vec_data[OUT_W-1:0];
            settle_cnt <= SETTLE_INIT;
            state      <= S_WAIT;
          end

          S_WAIT: begin
            if (settle_cnt == '0) begin
              state <= S_SAMPLE;
            end else begin
              settle_cnt <= settle_cnt - 8'd1;
            end
          end

          S_SAMPLE: begin
            if (mismatch) begin
              if (err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + CNT_W'(1);
              end
`ifdef TVEC_FIRST_FAIL_CAPTURE_EN
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                fail_addr  <= vec_addr;
                fail_got   <= dut_out;
              end
`endif
            end
            if (last_vec) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              vec_addr <= vec_addr + ADDR_W'(1);
              vec_rd   <= 1'b1;
              state    <= S_FETCH;
            end
          end

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tvec_sequencer.sv
// tb_tvec_sequencer
//   Three sequencer instances share start/abort/num_vec/rst_n:
//     0: SETTLE=1, CNT_W=16, circuit G=(A&B)|C, optionally stuck-at-0
//     1: SETTLE=1, CNT_W=2,  circuit always inverted (every vector mismatches)
//     2: SETTLE=4, CNT_W=16, circuit G with a 3-cycle output delay
//   A timeline model (run offset / vector period arithmetic) predicts every
//   output each cycle; directed literal checks pin the model.
`timescale 1ns/1ps
module tb_tvec_sequencer;
  localparam int unsigned IN_W   = 3;
  localparam int unsigned OUT_W  = 1;
  localparam int unsigned ADDR_W = 10;
  localparam int          ND     = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] num_vec = '0;
  logic              fault_a = 1'b0;

  logic              vec_rd   [ND];
  logic [ADDR_W-1:0] vec_addr [ND];
  logic [3:0]        vec_data [ND];
  logic [2:0]        dut_in   [ND];
  logic              dut_out  [ND];
  logic              busy     [ND];
  logic              done     [ND];
  logic [15:0]       err_a, err_c;
  logic [1:0]        err_b;
  logic [2:0]        dly;
`ifdef TVEC_FIRST_FAIL_CAPTURE_EN
  logic              fail_valid [ND];
  logic [ADDR_W-1:0] fail_addr  [ND];
  logic              fail_got   [ND];
`endif

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic g_of(input logic [2:0] v);
    return (v[2] & v[1]) | v[0];
  endfunction

  function automatic logic [3:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [2:0] s;
    s = a[2:0];
    return {s, g_of(s)};
  endfunction

  // synchronous vector memory, one per instance
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (vec_rd[d]) vec_data[d] <= rom_word(vec_addr[d]);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dly <= '0;
    else        dly <= {dly[1:0], g_of(dut_in[2])};
  end

  always_comb begin
    dut_out[0] = fault_a ? 1'b0 : g_of(dut_in[0]);
    dut_out[1] = ~g_of(dut_in[1]);
    dut_out[2] = dly[2];
  end

  tvec_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .SETTLE(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_vec(num_vec),
    .vec_rd(vec_rd[0]), .vec_addr(vec_addr[0]), .vec_data(vec_data[0]),
    .dut_in(dut_in[0]), .dut_out(dut_out[0]), .busy(busy[0]), .done(done[0]),
    .err_cnt(err_a)
`ifdef TVEC_FIRST_FAIL_CAPTURE_EN
    , .fail_valid(fail_valid[0]), .fail_addr(fail_addr[0]), .fail_got(fail_got[0])
`endif
  );

  tvec_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .SETTLE(1), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_vec(num_vec),
    .vec_rd(vec_rd[1]), .vec_addr(vec_addr[1]), .vec_data(vec_data[1]),
    .dut_in(dut_in[1]), .dut_out(dut_out[1]), .busy(busy[1]), .done(done[1]),
    .err_cnt(err_b)
`ifdef TVEC_FIRST_FAIL_CAPTURE_EN
    , .fail_valid(fail_valid[1]), .fail_addr(fail_addr[1]), .fail_got(fail_got[1])
`endif
  );

  tvec_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .SETTLE(4), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_vec(num_vec),
    .vec_rd(vec_rd[2]), .vec_addr(vec_addr[2]), .vec_data(vec_data[2]),
    .dut_in(dut_in[2]), .dut_out(dut_out[2]), .busy(busy[2]), .done(done[2]),
    .err_cnt(err_c)
`ifdef TVEC_FIRST_FAIL_CAPTURE_EN
    , .fail_valid(fail_valid[2]), .fail_addr(fail_addr[2]), .fail_got(fail_got[2])
`endif
  );

  function automatic int settle_of(input int d);
    return (d == 2) ? 4 : 1;
  endfunction

  function automatic int sat_of(input int d);
    return (d == 1) ? 3 : 65535;
  endfunction

  function automatic int err_of(input int d);
    case (d)
      0:       return int'(err_a);
      1:       return int'(err_b);
      default: return int'(err_c);
    endcase
  endfunction

  task automatic chk(input string name, input int d, input int got, input int expv);
    n_chk++;
    if (got == expv) n_pass++;
    else $display("FAIL %s[%0d]: got %0d expected %0d at %0t", name, d, got, expv, $time);
  endtask

  // ---------------- timeline model ----------------
  int m_run [ND];
  int m_t   [ND];
  int m_n   [ND];
  int e_rd  [ND];
  int e_addr[ND];
  int e_din [ND];
  int e_busy[ND];
  int e_done[ND];
  int e_err [ND];
  int e_fv  [ND];
  int e_fa  [ND];
  int e_fg  [ND];

  function automatic logic model_got(input int d, input int j);
    logic gj;
    gj = g_of(3'(j));
    if (d == 0) return fault_a ? 1'b0 : gj;
    if (d == 1) return ~gj;
    return gj;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_run[d] = 0; m_t[d] = 0; m_n[d] = 0;
      e_rd[d] = 0; e_addr[d] = 0; e_din[d] = 0; e_busy[d] = 0; e_done[d] = 0;
      e_err[d] = 0; e_fv[d] = 0; e_fa[d] = 0; e_fg[d] = 0;
    end
  endtask

  task automatic model_complete(input int d, input int j);
    logic gj, got;
    gj  = g_of(3'(j));
    got = model_got(d, j);
    if (got != gj) begin
      if (e_err[d] < sat_of(d)) e_err[d]++;
      if (e_fv[d] == 0) begin
        e_fv[d] = 1; e_fa[d] = j; e_fg[d] = int'(got);
      end
    end
  endtask

  task automatic model_step(input int d);
    int p;
    p = 3 + settle_of(d);
    e_done[d] = 0;
    if (m_run[d] == 0) begin
      if (start && !abort) begin
        e_err[d] = 0; e_fv[d] = 0; e_fa[d] = 0; e_fg[d] = 0;
        if (num_vec != 0) begin
          m_run[d] = 1; m_t[d] = 0; m_n[d] = int'(num_vec);
          e_busy[d] = 1; e_rd[d] = 1; e_addr[d] = 0;
        end else begin
          e_done[d] = 1;
        end
      end
    end else if (abort) begin
      m_run[d] = 0; e_busy[d] = 0; e_rd[d] = 0;
    end else begin
      m_t[d]++;
      if (m_t[d] % p == 0) model_complete(d, m_t[d] / p - 1);
      if (m_t[d] == m_n[d] * p) begin
        m_run[d] = 0; e_busy[d] = 0; e_rd[d] = 0; e_done[d] = 1;
      end else begin
        e_rd[d]   = (m_t[d] % p == 0) ? 1 : 0;
        e_addr[d] = m_t[d] / p;
        if (m_t[d] % p == 2) e_din[d] = (m_t[d] / p) % 8;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int d = 0; d < ND; d++) model_step(d);
    end
  end

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        chk("vec_rd",   d, int'(vec_rd[d]),   e_rd[d]);
        chk("vec_addr", d, int'(vec_addr[d]), e_addr[d]);
        chk("dut_in",   d, int'(dut_in[d]),   e_din[d]);
        chk("busy",     d, int'(busy[d]),     e_busy[d]);
        chk("done",     d, int'(done[d]),     e_done[d]);
        chk("err_cnt",  d, err_of(d),         e_err[d]);
`ifdef TVEC_FIRST_FAIL_CAPTURE_EN
        chk("fail_valid", d, int'(fail_valid[d]), e_fv[d]);
        chk("fail_addr",  d, int'(fail_addr[d]),  e_fa[d]);
        chk("fail_got",   d, int'(fail_got[d]),   e_fg[d]);
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic pulse_start(input int nv);
    num_vec = ADDR_W'(nv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget);
    for (int i = 0; i < budget && !done[d]; i++) @(negedge clk);
    chk("done_within_budget", d, int'(done[d]), 1);
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk({tag, "_vec_rd"},   d, int'(vec_rd[d]),   0);
      chk({tag, "_vec_addr"}, d, int'(vec_addr[d]), 0);
      chk({tag, "_dut_in"},   d, int'(dut_in[d]),   0);
      chk({tag, "_busy"},     d, int'(busy[d]),     0);
      chk({tag, "_done"},     d, int'(done[d]),     0);
      chk({tag, "_err"},      d, err_of(d),         0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_fetch, t_done_a, t_rd2, guard;

    // reset
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // clean run
    fault_a = 1'b0;
    pulse_start(8);
    t_fetch = cyc; t_done_a = -1; t_rd2 = -1;
    chk("first_fetch_rd", 0, int'(vec_rd[0]), 1);
    for (int i = 0; i < 200 && !done[2]; i++) begin
      @(negedge clk);
      if (done[0]) t_done_a = cyc;
      if (vec_rd[2] && t_rd2 < 0) t_rd2 = cyc;
    end
    chk("done_within_budget", 2, int'(done[2]), 1);
    chk("clean_run_cycles", 0, t_done_a - t_fetch, 32);
    chk("settle4_rd_period", 2, t_rd2 - t_fetch, 7);
    chk("clean_err", 0, err_of(0), 0);
    chk("clean_last_dut_in", 0, int'(dut_in[0]), 7);
    chk("delayed_circuit_err", 2, err_of(2), 0);
    chk("saturated_err", 1, err_of(1), 3);
    @(negedge clk);

    // fault run, num_vec changed mid-run must be ignored
    fault_a = 1'b1;
    pulse_start(8);
    repeat (3) @(negedge clk);
    num_vec = ADDR_W'(2);
    wait_done(2, 200);
    chk("stuck0_err", 0, err_of(0), 5);
`ifdef TVEC_FIRST_FAIL_CAPTURE_EN
    chk("stuck0_fail_valid", 0, int'(fail_valid[0]), 1);
    chk("stuck0_fail_addr",  0, int'(fail_addr[0]),  1);
    chk("stuck0_fail_got",   0, int'(fail_got[0]),   0);
`endif
    @(negedge clk);

    // empty run
    pulse_start(0);
    chk("empty_done", 0, int'(done[0]), 1);
    chk("empty_busy", 0, int'(busy[0]), 0);
    chk("empty_err_cleared", 0, err_of(0), 0);
    @(negedge clk);
    chk("empty_done_one_cycle", 0, int'(done[0]), 0);
    chk("empty_busy_after", 0, int'(busy[0]), 0);

    // abort during third vector's WAIT (instance 0)
    pulse_start(8);
    guard = 0;
    while (!(vec_rd[0] && vec_addr[0] == 10'd2) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_vec2_fetch", 0, (guard < 50) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 0, int'(busy[0]), 0);
    chk("abort_err_hold", 0, err_of(0), 1);
    chk("abort_dut_in_hold", 0, int'(dut_in[0]), 2);
    repeat (2) @(negedge clk);
    chk("abort_no_done", 0, int'(done[0]), 0);
    chk("abort_stays_idle", 0, int'(busy[0]), 0);

    // restart after abort
    pulse_start(8);
    chk("restart_addr", 0, int'(vec_addr[0]), 0);
    chk("restart_err", 0, err_of(0), 0);
    chk("restart_rd", 0, int'(vec_rd[0]), 1);
    wait_done(2, 200);
    @(negedge clk);

    // start together with abort in IDLE: no run
    num_vec = ADDR_W'(8);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 0, int'(busy[0]), 0);
    chk("start_abort_rd", 0, int'(vec_rd[0]), 0);
    @(negedge clk);
    chk("start_abort_no_done", 0, int'(done[0]), 0);

    // asynchronous reset mid-run
    pulse_start(8);
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", 0, int'(busy[0]), 1);
    chk("pre_reset_err_sat", 1, err_of(1), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // short run after reset
    fault_a = 1'b0;
    pulse_start(3);
    wait_done(2, 100);
    chk("post_reset_last_dut_in", 2, int'(dut_in[2]), 2);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tvec_sequencer.md
Name: tvec_sequencer

Overview:
- Hardware replacement for the file-driven vector loop: steps a combinational circuit under test through a stored test-vector table, one vector per step.
- For each vector: drives the stimulus, waits a settle window, samples the circuit output and compares it with the stored golden value.
- Counts mismatches for fault-injection campaigns.
- Sits between the vector memory (synchronous ROM/BRAM) and the circuit-under-test wrapper.

Parameters:
- IN_W, 3, stimulus width (circuit inputs, e.g. A,B,C).
- OUT_W, 1, circuit output width (e.g. G).
- ADDR_W, 10, vector memory address width.
- SETTLE, 1, cycles between driving stimulus and sampling output; legal range 1..255.
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begins a run; sampled only in IDLE.
- abort  in  1  terminates a run; highest priority.
- num_vec  in  ADDR_W  number of vectors; latched on start.
- vec_rd  out  1  memory read strobe.
- vec_addr  out  ADDR_W  memory address.
- vec_data  in  IN_W+OUT_W  memory data, valid 1 cycle after vec_rd. Upper IN_W bits are stimulus; lower OUT_W bits are expected output.
- dut_in  out  IN_W  stimulus to circuit under test.
- dut_out  in  OUT_W  circuit response.
- busy  out  1  high from the cycle after start until done or abort.
- done  out  1  one-cycle pulse at end of a completed run.
- err_cnt  out  CNT_W  mismatch count for the current or last run.

Behaviour:
- Reset values: vec_rd=0, vec_addr=0, dut_in=0, busy=0, done=0, err_cnt=0. State is IDLE.
- FSM states: IDLE, FETCH, LOAD, WAIT, SAMPLE.
- IDLE, start=1, num_vec!=0:
  - Latch num_vec.
  - Clear err_cnt and vec_addr.
  - Go to FETCH.
- IDLE, start=1, num_vec==0:
  - Clear err_cnt.
  - Pulse done on the next cycle.
  - Stay in IDLE; busy never rises.
- FETCH (1 cycle): vec_rd=1 with the current vec_addr. Go to LOAD.
- LOAD (1 cycle):
  - Register dut_in <= vec_data[IN_W+OUT_W-1:OUT_W].
  - Register exp <= vec_data[OUT_W-1:0].
  - Load settle counter with SETTLE-1. Go to WAIT.
- WAIT: decrement each cycle; when the counter is 0, go to SAMPLE. WAIT lasts exactly SETTLE cycles.
- SAMPLE (1 cycle):
  - Compare dut_out with exp; on any bit difference, err_cnt+1.
  - err_cnt saturates at all-ones (no wrap).
  - If vec_addr==num_vec-1: go to IDLE and pulse done in the same cycle busy falls.
  - Otherwise vec_addr+1 and go to FETCH.
- Per-vector cost is exactly 3+SETTLE cycles. A run costs N*(3+SETTLE) cycles from the first FETCH.
- dut_in holds the last vector after done. It changes only in LOAD or on reset.
- start while busy is ignored. num_vec changes mid-run are ignored.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; busy drops the next cycle.
  - done is not pulsed; err_cnt and dut_in hold.
  - abort in IDLE has no effect.
  - Simultaneous start and abort in IDLE: abort wins, no run starts.
- rst_n low mid-run immediately forces all reset values, asynchronously.
- vec_addr wrap cannot occur: num_vec is at most 2^ADDR_W-1 vectors. num_vec = all-ones runs addresses 0..2^ADDR_W-2.

Optional Feature:
- Macro: TVEC_FIRST_FAIL_CAPTURE_EN.
- When defined, add outputs:
  - fail_valid (1)
  - fail_addr (ADDR_W)
  - fail_got (OUT_W)
- On the first mismatch of a run, capture vec_addr and dut_out and set fail_valid.
- Later mismatches do not overwrite the capture.
- Capture clears on start and on reset; it holds after done and after abort.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Clean run: SETTLE=1, 8 vectors of G=(A&B)|C, circuit correct, num_vec=8 -> done 32 cycles after the first FETCH, err_cnt=0, dut_in=3'b111 at end.
- Fault run: same table, circuit output stuck-at-0 -> err_cnt=5 (the vectors with G=1). With the feature macro defined: fail_valid=1, fail_addr=1, fail_got=0.
- Empty run: num_vec=0, start -> done one cycle later, busy never high, err_cnt=0.
- Abort: start with num_vec=8, abort in the 3rd vector's WAIT -> busy low next cycle, no done, err_cnt unchanged. A new start restarts at vec_addr=0 with err_cnt=0.
- Saturation/async reset: CNT_W=2, all 8 vectors mismatching -> err_cnt=3. Then rst_n pulsed low mid-run -> all outputs return to 0 without waiting for a clock edge.
- Settle timing: SETTLE=4 -> vec_rd pulses every 7 cycles. Check that dut_out is sampled exactly 4 cycles after dut_in changes, using a circuit model with 3-cycle delayed output (err_cnt=0).
